// File: rtl/adc_serial_capture.sv
// Multi-channel serial ADC capture: one shared CS/SCLK pair, one data line per channel,
// enabled-channel samples presented as a packed word on a valid/ready stream.
module adc_serial_capture #(
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_MSB   = 13,
  parameter int DATA_LSB   = 2,
  parameter int SCLK_DIV   = 2,
  parameter int CS_SETUP   = 2,
  parameter int CYCLE_CNT  = 100,
  localparam int DW        = DATA_MSB - DATA_LSB + 1
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_CH-1:0]    en_i,
  input  logic                 mode_i,
  input  logic                 trigger_i,
  output logic                 busy_o,
  output logic [NUM_CH*DW-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 overrun_o,
  input  logic                 clr_ovr_i,
  input  logic [NUM_CH-1:0]    sdata_i,
  output logic                 sclk_o,
  output logic                 cs_o
);

  localparam int SW = $clog2(CS_SETUP + 1);
  localparam int VW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int PW = $clog2(CYCLE_CNT + 1);
  localparam logic [SW-1:0] SETUP_LAST  = SW'(CS_SETUP - 1);
  localparam logic [VW-1:0] DIV_LAST    = VW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL    = BW'(FRAME_BITS);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(CYCLE_CNT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  state_t state, state_d;

  logic [SW-1:0]               setup_cnt;
  logic [VW-1:0]               div_cnt;
  logic [BW-1:0]               bit_cnt;
  logic [PW-1:0]               period_cnt;
  logic [NUM_CH-1:0]           en_mask;
  // Bits above DATA_MSB fall off the top; bit 0 is always the last bit received.
  logic [NUM_CH-1:0][DATA_MSB:0] shreg;
  logic [NUM_CH*DW-1:0]        frame_data;
  logic start, setup_end, sclk_rise, sclk_fall, frame_end, accept, drop;

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    setup_end = 1'b0;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: if ((mode_i ? trigger_i : (period_cnt == '0)) && (en_i != '0)) begin
        start   = 1'b1;
        state_d = SETUP;
      end
      SETUP: if (setup_cnt == SETUP_LAST) begin
        setup_end = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: if (div_cnt == DIV_LAST) begin
        if (!sclk_o) begin
          sclk_rise = 1'b1;
        end else if (bit_cnt == BITS_ALL) begin
          frame_end = 1'b1;
          state_d   = DONE;
        end else begin
          sclk_fall = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en_mask[k]) frame_data[k*DW +: DW] = shreg[k][DATA_MSB:DATA_LSB];
    end
  end

  // Stream: a word transfers on a cycle with m_valid_o && m_ready_i; while valid and not
  // ready the word is frozen, and a frame finishing then is dropped and flagged as overrun.
  assign accept = (state == DONE) && (!m_valid_o || m_ready_i);
  assign drop   = (state == DONE) && m_valid_o && !m_ready_i;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_d;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_o       <= 1'b1;
      sclk_o     <= 1'b1;
      busy_o     <= 1'b0;
      setup_cnt  <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      period_cnt <= '0;
      en_mask    <= '0;
      shreg      <= '0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      busy_o <= (state_d != IDLE);

      if (start)                   period_cnt <= PERIOD_LOAD;
      else if (period_cnt != '0)   period_cnt <= period_cnt - 1'b1;

      if (start) begin
        en_mask   <= en_i;
        setup_cnt <= '0;
        cs_o      <= 1'b0;
      end else if (state == SETUP) begin
        setup_cnt <= setup_cnt + 1'b1;
      end

      if (setup_end) begin
        sclk_o  <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end

      if (sclk_rise) begin
        sclk_o  <= 1'b1;
        bit_cnt <= bit_cnt + 1'b1;
        for (int k = 0; k < NUM_CH; k++) shreg[k] <= {shreg[k][DATA_MSB-1:0], sdata_i[k]};
      end
      if (sclk_fall) sclk_o <= 1'b0;
      if (frame_end) cs_o <= 1'b1;

      if (accept) begin
        m_data_o  <= frame_data;
        m_valid_o <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end

      if (drop)           overrun_o <= 1'b1;
      else if (clr_ovr_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: table of continuous-mode frames plus
// hand-written sequences for backpressure, overrun, single-shot, async reset and idle.
module tb_adc_serial_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  en;
  logic        mode;
  logic        trigger;
  logic        busy_o;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        ready;
  logic        overrun_o;
  logic        clr_ovr;
  logic [1:0]  sdata = 2'b00;
  logic        sclk_o;
  logic        cs_o;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adc_serial_capture dut (
    .fpga_clk_i(clk), .reset_n_i(reset_n), .en_i(en), .mode_i(mode),
    .trigger_i(trigger), .busy_o(busy_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(ready), .overrun_o(overrun_o), .clr_ovr_i(clr_ovr), .sdata_i(sdata),
    .sclk_o(sclk_o), .cs_o(cs_o)
  );

  // ADC models: first bit goes out on the first SCLK falling edge after CS falls.
  logic [15:0] adc_word [2];
  int bit_idx = 0;
  always @(negedge cs_o) bit_idx = 15;
  always @(negedge sclk_o) begin
    if (!cs_o && bit_idx >= 0) begin
      sdata[0] = adc_word[0][bit_idx];
      sdata[1] = adc_word[1][bit_idx];
      bit_idx--;
    end
  end

  typedef struct {
    logic [1:0]  en;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (busy_o == lvl) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int limit, output logic ok, output logic [23:0] data,
                            output int cs_low, output int rises, output int busy_n,
                            output int cyc);
    logic prev_sclk;
    ok = 1'b0; data = '0; cs_low = 0; rises = 0; busy_n = 0; cyc = 0;
    prev_sclk = sclk_o;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (!cs_o) cs_low++;
      if (sclk_o && !prev_sclk) rises++;
      prev_sclk = sclk_o;
      if (busy_o) busy_n++;
      if (m_valid_o) begin
        ok   = 1'b1;
        data = m_data_o;
      end
    end
  endtask

  task automatic go_idle();
    logic ok;
    en = 2'b00;
    wait_busy(1'b0, 200, ok);
    check("idle_reached", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic        ok;
    logic [23:0] data, first;
    int          cs_low, rises, busy_n, cyc, bad, valids;

    vecs[0] = '{2'b11, 16'h1ABC, 16'h2F0F, 24'hBC36AF};
    vecs[1] = '{2'b01, 16'h1ABC, 16'h2F0F, 24'h0006AF};
    vecs[2] = '{2'b10, 16'h1ABC, 16'h2F0F, 24'hBC3000};
    vecs[3] = '{2'b11, 16'hFFFF, 16'h0000, 24'h000FFF};
    vecs[4] = '{2'b11, 16'h0003, 16'hC000, 24'h000000};
    vecs[5] = '{2'b11, 16'h0004, 16'h2000, 24'h800001};
    vecs[6] = '{2'b11, 16'hA5A5, 16'h5A5A, 24'h696969};

    reset_n = 1'b0; en = 2'b00; mode = 1'b0; trigger = 1'b0; ready = 1'b1; clr_ovr = 1'b0;
    adc_word[0] = 16'h1ABC; adc_word[1] = 16'h2F0F;

    @(negedge clk);
    check("rst_cs", cs_o, 1);
    check("rst_sclk", sclk_o, 1);
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Continuous-mode frames from the vector table.
    for (int i = 0; i < 7; i++) begin
      go_idle();
      adc_word[0] = vecs[i].w0;
      adc_word[1] = vecs[i].w1;
      en = vecs[i].en;
      wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
      check($sformatf("vec%0d_seen", i), ok, 1);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_cs_low", i), cs_low, 66);
      check($sformatf("vec%0d_sclk_rises", i), rises, 16);
      check($sformatf("vec%0d_busy", i), busy_n, 67);
    end
    wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
    check("period_cycles", cyc, 100);
    check("period_data", data, 24'h696969);

    // Backpressure: data frozen, overrun after the second DONE, clear pulse.
    go_idle();
    adc_word[0] = 16'h1ABC; adc_word[1] = 16'h2F0F;
    ready = 1'b0;
    en = 2'b11;
    wait_valid(300, ok, first, cs_low, rises, busy_n, cyc);
    check("bp_first_seen", ok, 1);
    check("bp_first_data", first, 24'hBC36AF);
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (!m_valid_o || m_data_o !== first) bad++;
    end
    check("bp_hold_bad_cycles", bad, 0);
    check("bp_overrun_set", overrun_o, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("bp_overrun_clr", overrun_o, 0);

    // Overrun set coinciding with a held clear: the set wins.
    clr_ovr = 1'b1;
    wait_busy(1'b1, 200, ok);
    check("sw_frame_start", ok, 1);
    wait_busy(1'b0, 100, ok);
    check("sw_frame_end", ok, 1);
    check("sw_set_wins", overrun_o, 1);
    clr_ovr = 1'b0;
    check("sw_data_kept", m_data_o, 24'hBC36AF);
    ready = 1'b1;
    @(negedge clk);
    check("sw_valid_drop", m_valid_o, 0);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("sw_overrun_clr", overrun_o, 0);

    // Enable change mid-SHIFT only affects the next frame.
    go_idle();
    en = 2'b01;
    wait_busy(1'b1, 200, ok);
    check("mid_frame_start", ok, 1);
    repeat (22) @(negedge clk);
    en = 2'b10;
    wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
    check("mid_cur_data", data, 24'h0006AF);
    wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
    check("mid_next_data", data, 24'hBC3000);

    // Single-shot: one trigger, one frame; a trigger during SHIFT is ignored.
    go_idle();
    mode = 1'b1;
    @(negedge clk);
    en = 2'b11;
    busy_n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
    end
    check("ss_no_auto_start", busy_n, 0);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    busy_n = 1;
    valids = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 30) trigger = 1'b1;
      if (i == 31) trigger = 1'b0;
      @(negedge clk);
      if (busy_o) busy_n++;
      if (m_valid_o) begin
        valids++;
        data = m_data_o;
      end
    end
    check("ss_busy_cycles", busy_n, 67);
    check("ss_valid_count", valids, 1);
    check("ss_data", data, 24'hBC36AF);
    mode = 1'b0;

    // Asynchronous reset in the middle of SHIFT while a word is held.
    go_idle();
    ready = 1'b0;
    en = 2'b11;
    wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
    check("ar_pre_valid", ok, 1);
    wait_busy(1'b1, 200, ok);
    check("ar_frame2_start", ok, 1);
    repeat (22) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_cs", cs_o, 1);
    check("ar_sclk", sclk_o, 1);
    check("ar_valid", m_valid_o, 0);
    check("ar_data", m_data_o, 0);
    check("ar_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check("ar_first_clock_start", busy_o, 1);
    wait_valid(300, ok, data, cs_low, rises, busy_n, cyc);
    check("ar_post_seen", ok, 1);
    check("ar_post_data", data, 24'hBC36AF);
    check("ar_post_cs_low", cs_low, 65);

    // All channels disabled: the interface stays quiet.
    go_idle();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!cs_o || !sclk_o || busy_o || m_valid_o) bad++;
    end
    check("idle_quiet_bad_cycles", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
Parametrised successor to the single-purpose dual-channel serial ADC interface. Drives a shared CS/SCLK pair to NUM_CH serial-output ADCs (AD7276-class and similar). Captures one data line per channel and presents enabled-channel samples as one packed word on a valid/ready stream with overrun detection. Runs entirely on one clock: SCLK is generated by an internal divider, with no second clock domain. Supports continuous (fixed-rate) and single-shot (triggered) conversion modes.

Parameters:
NUM_CH, 2, number of ADC data lines (1..8)
FRAME_BITS, 16, SCLK periods per conversion frame
DATA_MSB, 13, MSB of result slice within the received frame (bit 0 = last bit received)
DATA_LSB, 2, LSB of result slice; DW = DATA_MSB-DATA_LSB+1
SCLK_DIV, 2, fpga_clk_i cycles per SCLK half-period (>=1)
CS_SETUP, 2, cycles CS is low before the first SCLK falling edge (>=1)
CYCLE_CNT, 100, conversion period in fpga_clk_i cycles, start to start; must be >= CS_SETUP+2*SCLK_DIV*FRAME_BITS+2 (not checked)

Ports:
fpga_clk_i  in  1  system clock
reset_n_i  in  1  asynchronous, active-low reset
en_i  in  NUM_CH  per-channel enable mask
mode_i  in  1  0 = continuous, 1 = single-shot
trigger_i  in  1  single-shot start pulse
busy_o  out  1  high while not IDLE
m_data_o  out  NUM_CH*DW  packed samples; ch0 in the LSBs
m_valid_o  out  1  stream valid
m_ready_i  in  1  stream ready
overrun_o  out  1  sticky: a frame was dropped
clr_ovr_i  in  1  clears overrun_o
sdata_i  in  NUM_CH  serial data from the ADCs
sclk_o  out  1  ADC serial clock; idles high
cs_o  out  1  ADC chip select, active low

Behaviour:
- Reset is asynchronous and active-low: one clock (fpga_clk_i), reset_n_i. On assertion, outputs go immediately to: cs_o=1, sclk_o=1, m_valid_o=0, m_data_o=0, overrun_o=0, busy_o=0, state=IDLE, period counter=0.
- States: IDLE -> SETUP -> SHIFT -> DONE -> IDLE. All outputs are registered.
- IDLE start condition:
  - Continuous mode: period counter==0 and en_i!=0.
  - Single-shot mode: trigger_i==1 and en_i!=0.
  - On start: latch en_i into the enable mask, load the period counter with CYCLE_CNT-1 (it then decrements to 0 and holds), enter SETUP.
  - mode_i is sampled only in IDLE.
  - trigger_i outside IDLE is ignored.
- SETUP: cs_o=0, sclk_o=1, for CS_SETUP cycles, then SHIFT.
- SHIFT:
  - sclk_o toggles every SCLK_DIV cycles, starting low. Duration is 2*SCLK_DIV*FRAME_BITS cycles.
  - The ADC updates data on SCLK falling edges. The block samples sdata_i[k] into shift register k in the cycle in which sclk_o is driven low->high, MSB first.
  - After FRAME_BITS rising edges, sclk_o stays high and the FSM enters DONE.
- DONE (1 cycle):
  - cs_o=1.
  - Channel k field = shreg_k[DATA_MSB:DATA_LSB] if the latched mask bit k is 1, else 0.
  - Output load: if m_valid_o==0 or m_ready_i==1, load m_data_o and set m_valid_o=1.
  - Otherwise drop the new frame, keep the old data, set overrun_o=1.
  - Return to IDLE.
- Stream handshake:
  - m_valid_o holds until the cycle with m_ready_i=1, then clears unless a DONE load happens in the same cycle.
  - m_data_o is stable while valid and not ready.
- overrun_o:
  - Cleared by clr_ovr_i.
  - A set in the same cycle as clr_ovr_i wins.
- Timing with defaults:
  - Frame is SETUP 2 + SHIFT 64 + DONE 1 = 67 cycles.
  - cs_o is low for exactly 66 cycles per frame.
  - In continuous mode, frames start every 100 cycles.
- en_i changes mid-frame have no effect until the next start.
- Deasserting en_i to all zeros stops new frames; an in-flight frame completes.

Test Plan:
1. Defaults, continuous, en_i=2'b11; ADC models drive 0x1ABC (ch0) and 0x2F0F (ch1) MSB first on SCLK falling edges -> m_data_o=24'hBC36AF. Per frame: 16 sclk_o rising edges, cs_o low 66 cycles. Valid every 100 cycles with m_ready_i=1.
2. Same as 1 but m_ready_i=0 for 250 cycles -> m_data_o stays at the first frame's value. overrun_o=1 after the second DONE. clr_ovr_i pulse -> overrun_o=0.
3. en_i=2'b01, same ADC data -> m_data_o=24'h0006AF. en_i changed to 2'b10 mid-SHIFT -> current frame still 24'h0006AF; next frame 24'hBC3000.
4. mode_i=1, single trigger_i pulse -> exactly one frame, one valid, busy_o high 67 cycles. A second trigger_i during SHIFT starts no extra frame.
5. reset_n_i low at the 20th SHIFT cycle, asynchronous to the clock edge -> cs_o=1, sclk_o=1, m_valid_o=0 immediately. After release, the first frame starts on the first clock and its data is correct.
6. en_i=0 in continuous mode for 1000 cycles -> cs_o=1, sclk_o=1, busy_o=0, m_valid_o=0 throughout.
